// File: rtl/fifo_wr_packer.sv
// Packs RATIO consecutive IN_W-bit words into one OUT_W-bit FIFO entry through a one-entry skid.
// Define PACKER_FLUSH_EN to let an accepted in_last word close a partial entry (upper lanes zeroed).
module fifo_wr_packer #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 128,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    input  logic             fifo_full,
    output logic             fifo_write_en,
    output logic [OUT_W-1:0] fifo_data_in,
    output logic [1:0]       lane_cnt,
    output logic [CNT_W-1:0] push_cnt
);

    localparam int         RATIO     = OUT_W / IN_W;
    localparam logic [1:0] LAST_LANE = 2'(RATIO - 1);

    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] pend_data_q, pend_data_d;
    logic [OUT_W-1:0] merged;
    logic [1:0]       lane_q, lane_d;
    logic             pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0] push_cnt_q, push_cnt_d;
    logic             push, accept, ends_entry, complete;

`ifdef PACKER_FLUSH_EN
    assign ends_entry = (lane_q == LAST_LANE) || in_last;
`else
    assign ends_entry = (lane_q == LAST_LANE);
    logic unused_last;
    assign unused_last = in_last;
`endif

    // A completing word may enter only if the skid is free or drains this same cycle.
    assign push       = rst && pend_valid_q && !fifo_full;
    assign in_ready   = rst && (!ends_entry || !pend_valid_q || push);
    assign accept     = in_valid && in_ready;
    assign complete   = accept && ends_entry;

    assign fifo_write_en = push;
    assign fifo_data_in  = pend_data_q;
    assign lane_cnt      = lane_q;
    assign push_cnt      = push_cnt_q;

    // Upper lanes of acc are always zero, so a flushed partial entry is zero-padded for free.
    always_comb begin
        merged = acc_q;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (lane_q == 2'(k)) begin
                merged[k*IN_W +: IN_W] = in_data;
            end
        end
    end

    always_comb begin
        acc_d        = acc_q;
        lane_d       = lane_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        push_cnt_d   = push_cnt_q;

        if (push) begin
            pend_valid_d = 1'b0;
            push_cnt_d   = push_cnt_q + CNT_W'(1);
        end

        if (accept) begin
            if (complete) begin
                pend_data_d  = merged;
                pend_valid_d = 1'b1;
                lane_d       = '0;
                acc_d        = '0;
            end else begin
                acc_d  = merged;
                lane_d = lane_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q        <= '0;
            lane_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            push_cnt_q   <= '0;
        end else begin
            acc_q        <= acc_d;
            lane_q       <= lane_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            push_cnt_q   <= push_cnt_d;
        end
    end

endmodule
